// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux channel arbiter/multiplexer.
package arb_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Width of a channel index: ceil(log2(n)), never less than one bit.
  function automatic int sel_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Rotating-priority search: first set request at or above ptr_i, wrapping at N_CH-1.
module rr_pick #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(N_CH);

  logic [SEL_W:0] pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int i = 0; i < N_CH; i++) begin
      pos = {1'b0, ptr_i} + (SEL_W+1)'(i);
      if (pos >= NCH_L) pos = pos - NCH_L;
      if (!found_o && req_i[pos[SEL_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbiter feeding a single output register; fixed-select or round-robin.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int N_CH   = 4,
  localparam int SEL_W  = sel_w(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   mode_i,
  input  logic [SEL_W-1:0]       select_i,
  input  logic [N_CH-1:0]        valid_i,
  input  logic [N_CH*DATA_W-1:0] data_i,
  output logic [N_CH-1:0]        ready_o,
  output logic                   valid_o,
  output logic [DATA_W-1:0]      data_o,
  output logic [SEL_W-1:0]       grant_o,
  input  logic                   ready_i
);

  localparam logic [SEL_W:0]   NCH_L = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_found;
  logic [SEL_W-1:0]  cand;
  logic              cand_ok;
  logic              free;
  logic              xfer;
  logic [DATA_W-1:0] pick_data;

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req_i   (valid_i),
    .ptr_i   (rr_ptr),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

  // Free when empty or being drained this cycle, so refill can overlap the drain.
  assign free = !valid_o || ready_i;

  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    if (mode_i == MODE_RR) begin
      cand    = rr_idx;
      cand_ok = rr_found;
    end else begin
      cand    = select_i;
      cand_ok = ({1'b0, select_i} < NCH_L) && valid_i[select_i];
    end
  end

  assign xfer    = free && cand_ok;
  assign ready_o = (xfer && rst_n_i) ? ({{(N_CH-1){1'b0}}, 1'b1} << cand) : '0;

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < N_CH; k++)
      if (cand == SEL_W'(k)) pick_data = data_i[k*DATA_W +: DATA_W];
  end

  // Output register stage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      grant_o <= '0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      valid_o <= 1'b1;
      data_o  <= pick_data;
      grant_o <= cand;
      if (mode_i == MODE_RR) rr_ptr <= (cand == LAST) ? '0 : cand + 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: directed scenarios plus a cycle-by-cycle reference model.
module tb_arb_mux;
  import arb_mux_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b1;

  // 4-channel instance
  logic        mode4 = 1'b0;
  logic [1:0]  select4 = '0;
  logic [3:0]  valid4 = '0;
  logic [31:0] ch_data [4];
  logic [127:0] data4;
  logic [3:0]  ready4;
  logic        vld4;
  logic [31:0] dout4;
  logic [1:0]  grant4;
  logic        rdy_in4 = 1'b0;

  // 3-channel instance, held at an out-of-range select
  logic        mode3 = 1'b0;
  logic [1:0]  select3 = 2'd3;
  logic [2:0]  valid3 = 3'b111;
  logic [95:0] data3 = {32'h33330002, 32'h33330001, 32'h33330000};
  logic [2:0]  ready3;
  logic        vld3;
  logic [31:0] dout3;
  logic [1:0]  grant3;
  logic        rdy_in3 = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  bit          m_valid = 1'b0;
  logic [31:0] m_data = '0;
  int          m_grant = 0;
  int          m_ptr = 0;

  assign data4 = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  always #5 clk_i = ~clk_i;

  arb_mux #(.DATA_W(32), .N_CH(4)) u_dut4 (
    .clk_i(clk_i), .rst_n_i(rst_n), .mode_i(mode4), .select_i(select4),
    .valid_i(valid4), .data_i(data4), .ready_o(ready4), .valid_o(vld4),
    .data_o(dout4), .grant_o(grant4), .ready_i(rdy_in4)
  );

  arb_mux #(.DATA_W(32), .N_CH(3)) u_dut3 (
    .clk_i(clk_i), .rst_n_i(rst_n), .mode_i(mode3), .select_i(select3),
    .valid_i(valid3), .data_i(data3), .ready_o(ready3), .valid_o(vld3),
    .data_o(dout3), .grant_o(grant3), .ready_i(rdy_in3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel the spec rules would accept right now, or -1.
  function automatic int model_pick();
    int c;
    int k;
    c = -1;
    if (!rst_n) return -1;
    if (m_valid && !rdy_in4) return -1;
    if (mode4 == MODE_RR) begin
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr + i) % 4;
        if (c < 0 && valid4[k[1:0]]) c = k;
      end
    end else if (valid4[select4]) begin
      c = int'(select4);
    end
    return c;
  endfunction

  always @(posedge clk_i or negedge rst_n) begin
    int c;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_grant = 0;
      m_ptr   = 0;
    end else begin
      c = model_pick();
      if (c >= 0) begin
        m_valid = 1'b1;
        m_data  = ch_data[c[1:0]];
        m_grant = c;
        if (mode4 == MODE_RR) m_ptr = (c + 1) % 4;
      end else if (rdy_in4) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin
    int c;
    if (cmp_en) begin
      c = model_pick();
      check("ready_o", 64'(ready4), (c < 0) ? 64'd0 : (64'd1 << c));
      check("valid_o", 64'(vld4), 64'(m_valid));
      check("data_o", 64'(dout4), 64'(m_data));
      check("grant_o", 64'(grant4), 64'(m_grant));
      check("n3_ready_o", 64'(ready3), 64'd0);
      check("n3_valid_o", 64'(vld3), 64'd0);
    end
  end

  initial begin
    int exp_seq [8];
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    ch_data[0] = 32'hA0000000;
    ch_data[1] = 32'hB1111111;
    ch_data[2] = 32'hCAFE0002;
    ch_data[3] = 32'hD3333333;
    valid4 = 4'b1111;

    // Reset state, with requests pending to show ready_o is forced low
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(vld4), 64'd0);
    check("rst_data", 64'(dout4), 64'd0);
    check("rst_grant", 64'(grant4), 64'd0);
    check("rst_ready", 64'(ready4), 64'd0);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;

    // Fixed select of channel 2
    mode4 = MODE_SEL; select4 = 2'd2; valid4 = 4'b0100; rdy_in4 = 1'b1;
    @(negedge clk_i);
    check("sel_ready", 64'(ready4), 64'h4);
    @(posedge clk_i); #1 valid4 = 4'b0000;
    @(negedge clk_i);
    check("sel_valid", 64'(vld4), 64'd1);
    check("sel_data", 64'(dout4), 64'hCAFE0002);
    check("sel_grant", 64'(grant4), 64'd2);

    // Round-robin over four busy channels
    @(posedge clk_i); #1 mode4 = MODE_RR; valid4 = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); @(negedge clk_i);
      check("rr_seq_grant", 64'(grant4), 64'(exp_seq[i]));
      check("rr_seq_valid", 64'(vld4), 64'd1);
    end

    // Move pointer to 3, then requests on 0 and 1 only
    valid4 = 4'b0100;
    @(posedge clk_i); #1 valid4 = 4'b0011;
    @(negedge clk_i);
    check("rr_to3_grant", 64'(grant4), 64'd2);
    @(posedge clk_i); @(negedge clk_i);
    check("rr_wrap_grant", 64'(grant4), 64'd0);
    @(posedge clk_i); #1 rdy_in4 = 1'b0; mode4 = MODE_SEL; select4 = 2'd3; valid4 = 4'b1111;
    @(negedge clk_i);
    check("rr_ptr1_grant", 64'(grant4), 64'd1);
    check("rr_ptr1_data", 64'(dout4), 64'hB1111111);

    // Stall for five cycles, then drain and refill together
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); @(negedge clk_i);
      check("stall_ready", 64'(ready4), 64'd0);
      check("stall_grant", 64'(grant4), 64'd1);
      check("stall_data", 64'(dout4), 64'hB1111111);
      check("stall_valid", 64'(vld4), 64'd1);
    end
    rdy_in4 = 1'b1;
    #1 check("refill_ready", 64'(ready4), 64'h8);
    @(posedge clk_i); @(negedge clk_i);
    check("refill_grant", 64'(grant4), 64'd3);
    check("refill_data", 64'(dout4), 64'hD3333333);
    check("refill_valid", 64'(vld4), 64'd1);

    // Reset pulsed in the middle of a stall
    rdy_in4 = 1'b0; mode4 = MODE_RR; valid4 = 4'b1111;
    @(posedge clk_i); @(posedge clk_i);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(vld4), 64'd0);
    check("midrst_data", 64'(dout4), 64'd0);
    check("midrst_grant", 64'(grant4), 64'd0);
    check("midrst_ready", 64'(ready4), 64'd0);
    @(posedge clk_i); #1 rst_n = 1'b1; rdy_in4 = 1'b1;
    @(negedge clk_i);
    check("post_rst_ready", 64'(ready4), 64'h1);
    @(posedge clk_i); @(negedge clk_i);
    check("post_rst_grant", 64'(grant4), 64'd0);
    check("post_rst_valid", 64'(vld4), 64'd1);

    // Mixed traffic checked by the model alone
    for (int i = 0; i < 80; i++) begin
      @(posedge clk_i); #1;
      mode4   = 1'($urandom_range(0, 1));
      select4 = 2'($urandom_range(0, 3));
      valid4  = 4'($urandom);
      rdy_in4 = ($urandom_range(0, 3) != 0);
      ch_data[i % 4] = $urandom;
    end
    @(posedge clk_i); #1 valid4 = '0; rdy_in4 = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
